emulib_ckpt_sched: RTL and testbench

Checkpoint scheduler that sequences the scan-chain DMA controller (`EmuScanCtrl`-style `dma_start`/`dma_direction`/`dma_running` interface). It accepts host save/load commands and generates periodic automatic saves. For each operation it:
- halts the emulated clock and waits for halt acknowledge;
- starts the scan DMA with a stable direction and waits for completion;
- resumes emulation and reports completion.

Saves rotate through a ring of `NUM_SLOTS` checkpoint buffers.

---
 rtl/emulib_ckpt_sched.sv | 111 +++++++++++
 tb/tb_emulib_ckpt_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/emulib_ckpt_sched.sv
// emulib_ckpt_sched: sequences halt, scan DMA and resume for host and periodic checkpoint saves/loads
module emulib_ckpt_sched #(
  parameter int NUM_SLOTS = 4,
  parameter int PERIOD_WIDTH = 32,
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                    host_clk,
  input  logic                    host_rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [PERIOD_WIDTH-1:0] cmd_arg,
  output logic                    emu_halt,
  input  logic                    emu_halted,
  output logic                    scan_start,
  output logic                    scan_direction,
  input  logic                    scan_running,
  output logic [SLOT_W-1:0]       scan_slot,
  output logic                    done_valid,
  output logic [1:0]              done_op,
  output logic                    done_err,
  output logic [SLOT_W-1:0]       done_slot,
  output logic                    busy,
  output logic [31:0]             save_count
);
  typedef enum logic [2:0] {IDLE, HALT, START, WAIT_RUN, WAIT_DONE, RESUME, DONE} state_t;
  state_t state;
  logic [SLOT_W-1:0] wr_slot;
  logic [PERIOD_WIDTH-1:0] period_reg, timer;
  logic auto_pend, load_ok, tick;
  assign load_ok = cmd_arg < PERIOD_WIDTH'(NUM_SLOTS);
  assign tick = period_reg != '0 && !emu_halted && !auto_pend;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign emu_halt = state inside {HALT, START, WAIT_RUN, WAIT_DONE};
  assign scan_start = state == START;
  assign done_valid = state == DONE;
  assign done_slot = scan_slot;
  always_ff @(posedge host_clk or negedge host_rst_n)
    if (!host_rst_n) begin
      state <= IDLE;
      wr_slot <= '0;
      period_reg <= '0;
      timer <= '0;
      auto_pend <= 1'b0;
      scan_direction <= 1'b0;
      scan_slot <= '0;
      done_op <= '0;
      done_err <= 1'b0;
      save_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            timer <= (timer < PERIOD_WIDTH'(2)) ? period_reg : timer - 1'b1;
            auto_pend <= timer < PERIOD_WIDTH'(2);
          end
          // later assignments below let a host command override the timer's decision
          if (cmd_valid) begin
            case (cmd_op)
              2'd0: begin
                state <= HALT;
                done_op <= 2'd0;
                done_err <= 1'b0;
                scan_direction <= 1'b0;
                scan_slot <= wr_slot;
                auto_pend <= 1'b0;
              end
              2'd1: begin
                state <= load_ok ? HALT : DONE;
                done_op <= 2'd1;
                done_err <= !load_ok;
                scan_direction <= 1'b1;
                scan_slot <= cmd_arg[SLOT_W-1:0];
              end
              2'd2: begin
                period_reg <= cmd_arg;
                timer <= cmd_arg;
                auto_pend <= auto_pend;
              end
              default: begin
                state <= DONE;
                done_op <= cmd_op;
                done_err <= 1'b1;
              end
            endcase
          end else if (auto_pend) begin
            state <= HALT;
            done_op <= 2'd0;
            done_err <= 1'b0;
            scan_direction <= 1'b0;
            scan_slot <= wr_slot;
            auto_pend <= 1'b0;
          end
        end
        HALT: state <= (emu_halted && !scan_running) ? START : HALT;
        START: state <= WAIT_RUN;
        WAIT_RUN: state <= scan_running ? WAIT_DONE : WAIT_RUN;
        WAIT_DONE: state <= scan_running ? WAIT_DONE : RESUME;
        RESUME: begin
          if (done_op == 2'd0) begin
            wr_slot <= (wr_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : wr_slot + 1'b1;
            save_count <= save_count + 32'd1;
          end
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_emulib_ckpt_sched.sv
// tb_emulib_ckpt_sched: randomized scenario bench with emulation/scan responders and a slot-ring model
module tb_emulib_ckpt_sched;
  localparam int NS = 4;
  logic host_clk = 0, host_rst_n = 0, cmd_valid = 0;
  logic [1:0] cmd_op = 0;
  logic [31:0] cmd_arg = 0;
  logic cmd_ready, emu_halt, emu_halted, scan_start, scan_direction, done_valid, done_err, busy;
  logic scan_running = 0;
  logic [1:0] scan_slot, done_op, done_slot;
  logic [31:0] save_count;
  logic halted_r = 0, force_halted = 0, inst_halt = 0;
  int halt_lat = 3, scan_lat = 20, hc = 0, sc = 0, viol = 0;
  int checks = 0, passes = 0;
  int exp_wr = 0;
  logic [31:0] exp_saves = 0;
  logic [1:0] r_op, r_slot, r_sslot;
  logic r_err, r_start, r_dir;
  logic [31:0] r_cnt;
  logic [2:0] r_tail;

  emulib_ckpt_sched #(.NUM_SLOTS(NS), .PERIOD_WIDTH(32)) dut (
    .host_clk(host_clk), .host_rst_n(host_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .emu_halt(emu_halt), .emu_halted(emu_halted),
    .scan_start(scan_start), .scan_direction(scan_direction), .scan_running(scan_running),
    .scan_slot(scan_slot), .done_valid(done_valid), .done_op(done_op), .done_err(done_err),
    .done_slot(done_slot), .busy(busy), .save_count(save_count)
  );

  always #5 host_clk = ~host_clk;
  assign emu_halted = force_halted | (inst_halt ? emu_halt : halted_r);

  // emulated-clock controller: acknowledges a halt request after halt_lat cycles
  always @(posedge host_clk)
    if (!emu_halt) begin hc <= 0; halted_r <= 0; end
    else begin hc <= hc + 1; if (hc + 1 >= halt_lat) halted_r <= 1; end

  // scan DMA controller: busy for scan_lat cycles after each start pulse
  always @(posedge host_clk)
    if (scan_start) begin scan_running <= 1; sc <= scan_lat; end
    else if (sc > 1) sc <= sc - 1;
    else if (sc == 1) begin sc <= 0; scan_running <= 0; end

  always @(negedge host_clk) if (scan_start && scan_running) viol++;

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] arg);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 2000) begin @(negedge host_clk); n++; end
    if (n >= 2000) begin checks++; $display("FAIL cmd_ready_timeout got=%b exp=1", cmd_ready); end
    cmd_valid = 1; cmd_op = op; cmd_arg = arg;
    @(negedge host_clk);
    cmd_valid = 0;
  endtask

  task automatic wait_done(input string tag);
    logic ph = 0, pph = 0, pb = 0;
    bit ok = 0;
    r_start = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (scan_start) begin r_start = 1; r_dir = scan_direction; r_sslot = scan_slot; end
      if (done_valid) begin
        ok = 1; r_op = done_op; r_err = done_err; r_slot = done_slot; r_cnt = save_count; r_tail = {pph, ph, pb};
      end else begin
        pph = ph; ph = emu_halt; pb = busy;
        @(negedge host_clk);
      end
    end
    if (!ok) begin checks++; $display("FAIL %s_timeout done_valid never seen, exp within 2000 cycles", tag); end
  endtask

  task automatic test_reset;
    host_rst_n = 0;
    repeat (2) @(negedge host_clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
    checks++; if (emu_halt !== 1'b0) $display("FAIL reset_halt got=%b exp=0", emu_halt); else passes++;
    checks++; if (scan_start !== 1'b0) $display("FAIL reset_start got=%b exp=0", scan_start); else passes++;
    checks++; if (done_valid !== 1'b0) $display("FAIL reset_done got=%b exp=0", done_valid); else passes++;
    checks++; if (save_count !== 32'd0) $display("FAIL reset_count got=%0d exp=0", save_count); else passes++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", cmd_ready); else passes++;
    host_rst_n = 1;
    @(negedge host_clk);
  endtask

  task automatic test_save_ring;
    halt_lat = 3; scan_lat = 20;
    for (int k = 0; k < 5; k++) begin
      do_cmd(2'd0, 32'd0);
      wait_done("ring");
      checks++; if (r_op !== 2'd0 || r_err !== 1'b0) $display("FAIL ring_op got=%0d/%b exp=0/0", r_op, r_err); else passes++;
      checks++; if (r_slot !== 2'(exp_wr)) $display("FAIL ring_slot got=%0d exp=%0d", r_slot, exp_wr); else passes++;
      checks++; if ({r_start, r_dir} !== 2'b10) $display("FAIL ring_dir got=%b exp=10", {r_start, r_dir}); else passes++;
      checks++; if (r_tail !== 3'b101) $display("FAIL ring_resume got=%b exp=101", r_tail); else passes++;
      exp_wr = (exp_wr + 1) % NS; exp_saves++;
      checks++; if (r_cnt !== exp_saves) $display("FAIL ring_count got=%0d exp=%0d", r_cnt, exp_saves); else passes++;
    end
  endtask

  task automatic test_save_latency;
    force_halted = 1; scan_lat = 4;
    do_cmd(2'd0, 32'd0);
    checks++; if ({busy, emu_halt, scan_start} !== 3'b110) $display("FAIL lat_t1 got=%b exp=110", {busy, emu_halt, scan_start}); else passes++;
    @(negedge host_clk);
    checks++; if ({scan_start, scan_direction} !== 2'b10) $display("FAIL lat_t2 got=%b exp=10", {scan_start, scan_direction}); else passes++;
    checks++; if (scan_slot !== 2'(exp_wr)) $display("FAIL lat_slot got=%0d exp=%0d", scan_slot, exp_wr); else passes++;
    @(negedge host_clk);
    checks++; if ({scan_start, emu_halt} !== 2'b01) $display("FAIL lat_t3 got=%b exp=01", {scan_start, emu_halt}); else passes++;
    wait_done("lat");
    checks++; if (r_slot !== 2'(exp_wr)) $display("FAIL lat_done_slot got=%0d exp=%0d", r_slot, exp_wr); else passes++;
    exp_wr = (exp_wr + 1) % NS; exp_saves++;
    checks++; if (r_cnt !== exp_saves) $display("FAIL lat_count got=%0d exp=%0d", r_cnt, exp_saves); else passes++;
    force_halted = 0;
  endtask

  task automatic test_load;
    halt_lat = 2; scan_lat = 6;
    do_cmd(2'd1, 32'd2);
    wait_done("load");
    checks++; if ({r_op, r_err} !== 3'b010) $display("FAIL load_op got=%b exp=010", {r_op, r_err}); else passes++;
    checks++; if ({r_start, r_dir, r_sslot} !== 4'b1110) $display("FAIL load_scan got=%b exp=1110", {r_start, r_dir, r_sslot}); else passes++;
    checks++; if (r_slot !== 2'd2) $display("FAIL load_slot got=%0d exp=2", r_slot); else passes++;
    checks++; if (r_cnt !== exp_saves) $display("FAIL load_count got=%0d exp=%0d", r_cnt, exp_saves); else passes++;
    do_cmd(2'd1, 32'd4);
    checks++; if ({done_valid, done_err, done_op} !== 4'b1101) $display("FAIL badload got=%b exp=1101", {done_valid, done_err, done_op}); else passes++;
    checks++; if ({emu_halt, scan_start} !== 2'b00) $display("FAIL badload_halt got=%b exp=00", {emu_halt, scan_start}); else passes++;
    @(negedge host_clk);
    checks++; if (busy !== 1'b0) $display("FAIL badload_idle got=%b exp=0", busy); else passes++;
    do_cmd(2'd3, $urandom);
    checks++; if ({done_valid, done_err, done_op} !== 4'b1111) $display("FAIL reserved got=%b exp=1111", {done_valid, done_err, done_op}); else passes++;
  endtask

  task automatic test_random;
    for (int k = 0; k < 12; k++) begin
      int sel = $urandom_range(0, 2);
      int arg = $urandom_range(0, 6);
      logic [1:0] op = (sel == 2) ? 2'd3 : 2'(sel);
      logic e_err = (sel == 2) || (sel == 1 && arg >= NS);
      int e_slot = (sel == 0) ? exp_wr : arg;
      halt_lat = $urandom_range(0, 4); scan_lat = $urandom_range(1, 8);
      do_cmd(op, 32'(arg));
      wait_done("rand");
      if (sel == 0) begin exp_wr = (exp_wr + 1) % NS; exp_saves++; end
      checks++; if ({r_op, r_err} !== {op, e_err}) $display("FAIL rand_op got=%b exp=%b", {r_op, r_err}, {op, e_err}); else passes++;
      checks++; if (r_start !== !e_err) $display("FAIL rand_start got=%b exp=%b", r_start, !e_err); else passes++;
      if (!e_err) begin
        checks++; if ({r_dir, r_slot} !== {sel == 1, 2'(e_slot)}) $display("FAIL rand_slot got=%b exp=%b", {r_dir, r_slot}, {sel == 1, 2'(e_slot)}); else passes++;
      end
      checks++; if (r_cnt !== exp_saves) $display("FAIL rand_count got=%0d exp=%0d", r_cnt, exp_saves); else passes++;
    end
  endtask

  task automatic test_busy_ignore;
    int n = 0, bad = 0;
    halt_lat = 2; scan_lat = 20;
    do_cmd(2'd1, 32'd1);
    while (done_valid !== 1'b1 && n < 500) begin
      if (cmd_ready !== 1'b0 || scan_direction !== 1'b1 || scan_slot !== 2'd1) bad++;
      cmd_valid = 1; cmd_op = 2'($urandom_range(0, 3)); cmd_arg = $urandom;
      @(negedge host_clk);
      n++;
    end
    cmd_valid = 0;
    checks++; if (bad != 0) $display("FAIL busy_latch got=%0d bad cycles exp=0", bad); else passes++;
    checks++; if ({done_valid, done_op, done_slot} !== 5'b10101) $display("FAIL busy_done got=%b exp=10101", {done_valid, done_op, done_slot}); else passes++;
    checks++; if (save_count !== exp_saves) $display("FAIL busy_count got=%0d exp=%0d", save_count, exp_saves); else passes++;
    repeat (2) @(negedge host_clk);
    checks++; if (busy !== 1'b0) $display("FAIL busy_extra got=%b exp=0", busy); else passes++;
  endtask

  task automatic test_period;
    int n, starts;
    inst_halt = 1; force_halted = 0; scan_lat = 5;
    do_cmd(2'd2, 32'd10);
    n = 1;
    while (scan_start !== 1'b1 && n < 200) begin @(negedge host_clk); n++; end
    checks++; if (n != 13) $display("FAIL auto_delay got=%0d exp=13", n); else passes++;
    wait_done("auto1");
    checks++; if ({r_op, r_slot} !== {2'd0, 2'(exp_wr)}) $display("FAIL auto1_slot got=%b exp=%b", {r_op, r_slot}, {2'd0, 2'(exp_wr)}); else passes++;
    exp_wr = (exp_wr + 1) % NS; exp_saves++;
    checks++; if (r_cnt !== exp_saves) $display("FAIL auto1_count got=%0d exp=%0d", r_cnt, exp_saves); else passes++;
    force_halted = 1;
    do_cmd(2'd2, 32'd10);
    starts = 0;
    repeat (30) begin @(negedge host_clk); if (scan_start) starts++; end
    checks++; if (starts != 0) $display("FAIL frozen_starts got=%0d exp=0", starts); else passes++;
    force_halted = 0;
    n = 0;
    while (scan_start !== 1'b1 && n < 200) begin @(negedge host_clk); n++; end
    checks++; if (n != 12) $display("FAIL frozen_delay got=%0d exp=12", n); else passes++;
    wait_done("auto2");
    checks++; if (r_slot !== 2'(exp_wr)) $display("FAIL auto2_slot got=%0d exp=%0d", r_slot, exp_wr); else passes++;
    exp_wr = (exp_wr + 1) % NS; exp_saves++;
    do_cmd(2'd2, 32'd4);
    repeat (3) @(negedge host_clk);
    do_cmd(2'd2, 32'd7);
    n = 1;
    while (scan_start !== 1'b1 && n < 200) begin @(negedge host_clk); n++; end
    checks++; if (n != 10) $display("FAIL override_delay got=%0d exp=10", n); else passes++;
    wait_done("auto3");
    exp_wr = (exp_wr + 1) % NS; exp_saves++;
    checks++; if (r_cnt !== exp_saves) $display("FAIL auto3_count got=%0d exp=%0d", r_cnt, exp_saves); else passes++;
    do_cmd(2'd2, 32'd0);
    starts = 0;
    repeat (1000) begin @(negedge host_clk); if (scan_start || done_valid) starts++; end
    checks++; if (starts != 0) $display("FAIL period0_starts got=%0d exp=0", starts); else passes++;
  endtask

  task automatic test_coincident;
    inst_halt = 1; scan_lat = 5;
    do_cmd(2'd2, 32'd5);
    repeat (5) @(negedge host_clk);
    do_cmd(2'd1, 32'd3);
    wait_done("coinc_load");
    checks++; if ({r_op, r_slot} !== 4'b0111) $display("FAIL coinc_first got=%b exp=0111", {r_op, r_slot}); else passes++;
    @(negedge host_clk);
    checks++; if (busy !== 1'b0) $display("FAIL coinc_gap got=%b exp=0", busy); else passes++;
    @(negedge host_clk);
    checks++; if (emu_halt !== 1'b1) $display("FAIL coinc_autostart got=%b exp=1", emu_halt); else passes++;
    wait_done("coinc_auto");
    checks++; if ({r_op, r_slot} !== {2'd0, 2'(exp_wr)}) $display("FAIL coinc_second got=%b exp=%b", {r_op, r_slot}, {2'd0, 2'(exp_wr)}); else passes++;
    exp_wr = (exp_wr + 1) % NS; exp_saves++;
    do_cmd(2'd2, 32'd0);
    do_cmd(2'd2, 32'd5);
    repeat (5) @(negedge host_clk);
    do_cmd(2'd0, 32'd0);
    wait_done("coinc_save");
    checks++; if (r_slot !== 2'(exp_wr)) $display("FAIL coinc_save_slot got=%0d exp=%0d", r_slot, exp_wr); else passes++;
    exp_wr = (exp_wr + 1) % NS; exp_saves++;
    checks++; if (r_cnt !== exp_saves) $display("FAIL coinc_save_count got=%0d exp=%0d", r_cnt, exp_saves); else passes++;
    for (int i = 0; i < 3; i++) begin
      @(negedge host_clk);
      checks++; if (busy !== 1'b0) $display("FAIL coinc_cleared cyc=%0d got=%b exp=0", i, busy); else passes++;
    end
    do_cmd(2'd2, 32'd0);
  endtask

  task automatic test_reset_mid;
    int n = 0;
    inst_halt = 0; halt_lat = 1; scan_lat = 20;
    do_cmd(2'd0, 32'd0);
    while (scan_running !== 1'b1 && n < 200) begin @(negedge host_clk); n++; end
    repeat (3) @(negedge host_clk);
    checks++; if (busy !== 1'b1) $display("FAIL mid_busy got=%b exp=1", busy); else passes++;
    host_rst_n = 0;
    #1;
    checks++; if ({emu_halt, busy, scan_start, done_valid} !== 4'b0000) $display("FAIL mid_reset got=%b exp=0000", {emu_halt, busy, scan_start, done_valid}); else passes++;
    checks++; if (save_count !== 32'd0) $display("FAIL mid_count got=%0d exp=0", save_count); else passes++;
    @(negedge host_clk);
    host_rst_n = 1;
    exp_wr = 0; exp_saves = 0;
    do_cmd(2'd0, 32'd0);
    wait_done("mid_save");
    checks++; if (r_slot !== 2'd0) $display("FAIL mid_slot got=%0d exp=0", r_slot); else passes++;
    checks++; if (r_cnt !== 32'd1) $display("FAIL mid_save_count got=%0d exp=1", r_cnt); else passes++;
  endtask

  initial begin
    test_reset;
    test_save_ring;
    test_save_latency;
    test_load;
    test_random;
    test_busy_ignore;
    test_period;
    test_coincident;
    test_reset_mid;
    checks++; if (viol != 0) $display("FAIL start_while_running got=%0d exp=0", viol); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
